// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: prescaled shared up-counter with per-channel [cr1, cr2) windows.
// Period and compare values are double-buffered and switch over only at a period wrap.
module pwm_multi #(
  parameter int                  CHANNELS   = 4,
  parameter int                  WIDTH      = 16,
  parameter int                  PRESCALE   = 250,
  parameter logic [WIDTH-1:0]    PERIOD_RST = WIDTH'(9999),
  parameter logic [CHANNELS-1:0] INVERT     = '0
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic                      load_i,
  input  logic [WIDTH-1:0]          period_i,
  input  logic [CHANNELS*WIDTH-1:0] cr1_i,
  input  logic [CHANNELS*WIDTH-1:0] cr2_i,
  output logic [CHANNELS-1:0]       pwm_o,
  output logic                      overflow_o,
  output logic [WIDTH-1:0]          count_o
);

  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] per_act_q, per_stg_q;
  logic             overflow_q;
  logic             pending_q, pending_d;
  logic             tick, wrap;
  logic             act_from_port, act_from_stg;

  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    tick      = 1'b0;
    wrap      = 1'b0;
    pending_d = pending_q;
    if (!enable_i) begin
      presc_d = '0;
      count_d = '0;
    end else begin
      tick    = (presc_q == PRESC_LAST);
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        wrap    = (count_q == per_act_q);
        count_d = wrap ? '0 : count_q + WIDTH'(1);
      end
    end
    // While stopped there is no wrap to wait for, so updates land at once.
    act_from_port = load_i && (!enable_i || wrap);
    act_from_stg  = !load_i && pending_q && (!enable_i || wrap);
    if (act_from_port || act_from_stg) begin
      pending_d = 1'b0;
    end else if (load_i) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      presc_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      pending_q  <= 1'b0;
      per_act_q  <= PERIOD_RST;
      per_stg_q  <= PERIOD_RST;
    end else begin
      presc_q    <= presc_d;
      count_q    <= count_d;
      overflow_q <= wrap;
      pending_q  <= pending_d;
      if (load_i) begin
        per_stg_q <= period_i;
      end
      if (act_from_port) begin
        per_act_q <= period_i;
      end else if (act_from_stg) begin
        per_act_q <= per_stg_q;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] cr1_act_q, cr2_act_q;
      logic [WIDTH-1:0] cr1_stg_q, cr2_stg_q;
      logic             pwm_q;
      logic             raw;

      assign raw = (count_q >= cr1_act_q) && (count_q < cr2_act_q);

      always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
          cr1_act_q <= '0;
          cr2_act_q <= '0;
          cr1_stg_q <= '0;
          cr2_stg_q <= '0;
          pwm_q     <= INVERT[gi];
        end else begin
          if (load_i) begin
            cr1_stg_q <= cr1_i[gi*WIDTH +: WIDTH];
            cr2_stg_q <= cr2_i[gi*WIDTH +: WIDTH];
          end
          if (act_from_port) begin
            cr1_act_q <= cr1_i[gi*WIDTH +: WIDTH];
            cr2_act_q <= cr2_i[gi*WIDTH +: WIDTH];
          end else if (act_from_stg) begin
            cr1_act_q <= cr1_stg_q;
            cr2_act_q <= cr2_stg_q;
          end
          pwm_q <= enable_i ? (raw ^ INVERT[gi]) : INVERT[gi];
        end
      end

      assign pwm_o[gi] = pwm_q;
    end
  endgenerate

  assign overflow_o = overflow_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: directed stimulus pushes hand-computed expectations (cycle, count, pwm, overflow)
// into a scoreboard; a negedge monitor pops and compares them when their cycle comes up.
module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic        load_i;
  logic [15:0] period_i;
  logic [63:0] cr1_w, cr2_w;
  logic [3:0]  pwm_o;
  logic        overflow_o;
  logic [15:0] count_o;

  logic [15:0] c1 [4];
  logic [15:0] c2 [4];

  assign cr1_w = {c1[3], c1[2], c1[1], c1[0]};
  assign cr2_w = {c2[3], c2[2], c2[1], c2[0]};

  pwm_multi #(
    .CHANNELS(4),
    .WIDTH(16),
    .PRESCALE(1),
    .PERIOD_RST(16'd9999),
    .INVERT(4'b0100)
  ) dut (
    .clock_i   (clk),
    .reset_i   (reset_i),
    .enable_i  (enable_i),
    .load_i    (load_i),
    .period_i  (period_i),
    .cr1_i     (cr1_w),
    .cr2_i     (cr2_w),
    .pwm_o     (pwm_o),
    .overflow_o(overflow_o),
    .count_o   (count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          q_cyc  [$];
  string       q_name [$];
  logic [20:0] q_val  [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [20:0] got;

  task automatic expect_at(input int at, input string nm, input logic [15:0] c,
                           input logic [3:0] p, input logic o);
    q_cyc.push_back(at);
    q_name.push_back(nm);
    q_val.push_back({c, p, o});
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      n_cmp++;
      got = {count_o, pwm_o, overflow_o};
      if (q_cyc[0] < cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", q_name[0], q_cyc[0], cyc);
      end else if (got !== q_val[0]) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got count=%0d pwm=%b ovf=%b, expected count=%0d pwm=%b ovf=%b",
                 q_name[0], cyc, count_o, pwm_o, overflow_o,
                 q_val[0][20:5], q_val[0][4:1], q_val[0][0]);
      end else begin
        $display("ok   %s @cyc %0d: count=%0d pwm=%b ovf=%b", q_name[0], cyc, count_o, pwm_o, overflow_o);
      end
      void'(q_cyc.pop_front());
      void'(q_name.pop_front());
      void'(q_val.pop_front());
    end
  end

  int p, q, r, s;

  initial begin
    reset_i  = 1'b1;
    enable_i = 1'b0;
    load_i   = 1'b0;
    period_i = '0;
    for (int i = 0; i < 4; i++) begin
      c1[i] = '0;
      c2[i] = '0;
    end

    step_to(2);
    expect_at(2, "reset_hold", 16'd0, 4'b0100, 1'b0);
    reset_i = 1'b0;

    // Load while stopped: takes effect immediately.
    step_to(3);
    period_i = 16'd99;
    c1[0] = 16'd0;  c2[0] = 16'd50;
    c1[1] = 16'd0;  c2[1] = 16'd20;
    c1[2] = 16'd30; c2[2] = 16'd30;
    c1[3] = 16'd0;  c2[3] = 16'd200;
    load_i = 1'b1;
    step_to(4);
    load_i   = 1'b0;
    enable_i = 1'b1;
    p = cyc;

    // Basic duty: ch0 high for counts 0..49, idle ch2 sits at inverted level, ch3 always on.
    expect_at(p + 1,   "duty_start",    16'd1,  4'b1111, 1'b0);
    expect_at(p + 50,  "duty_last_hi",  16'd50, 4'b1101, 1'b0);
    expect_at(p + 51,  "duty_first_lo", 16'd51, 4'b1100, 1'b0);
    expect_at(p + 100, "wrap1",         16'd0,  4'b1100, 1'b1);
    expect_at(p + 101, "after_wrap1",   16'd1,  4'b1111, 1'b0);

    // Mid-period load of ch1 cr2=80 at count 10: stays staged until the wrap.
    step_to(p + 110);
    c2[1]  = 16'd80;
    load_i = 1'b1;
    expect_at(p + 120, "shadow_old_hi", 16'd20, 4'b1111, 1'b0);
    expect_at(p + 121, "shadow_old_lo", 16'd21, 4'b1101, 1'b0);
    expect_at(p + 200, "wrap2",         16'd0,  4'b1100, 1'b1);
    expect_at(p + 201, "shadow_new_0",  16'd1,  4'b1111, 1'b0);
    expect_at(p + 280, "shadow_new_79", 16'd80, 4'b1110, 1'b0);
    expect_at(p + 281, "shadow_new_80", 16'd81, 4'b1100, 1'b0);
    step_to(p + 111);
    load_i = 1'b0;

    // Load coinciding with the wrap clock: new values apply from count 0.
    step_to(p + 299);
    c2[0] = 16'd25;
    c1[2] = 16'd10; c2[2] = 16'd20;
    load_i = 1'b1;
    expect_at(p + 300, "simul_wrap",  16'd0,  4'b1100, 1'b1);
    expect_at(p + 301, "simul_new_0", 16'd1,  4'b1111, 1'b0);
    expect_at(p + 311, "simul_inv10", 16'd11, 4'b1011, 1'b0);
    expect_at(p + 321, "simul_inv20", 16'd21, 4'b1111, 1'b0);
    expect_at(p + 326, "simul_ch0_25", 16'd26, 4'b1110, 1'b0);
    step_to(p + 300);
    load_i = 1'b0;

    // Stage ch0 cr2=60, then drop enable at count 40: pending update applies while stopped.
    step_to(p + 335);
    c2[0]  = 16'd60;
    load_i = 1'b1;
    step_to(p + 336);
    load_i = 1'b0;
    step_to(p + 340);
    enable_i = 1'b0;
    expect_at(p + 341, "disable_next", 16'd0, 4'b0100, 1'b0);
    expect_at(p + 345, "disable_hold", 16'd0, 4'b0100, 1'b0);
    step_to(p + 345);
    enable_i = 1'b1;
    q = cyc;
    expect_at(q + 1,  "reenable_0",   16'd1,  4'b1111, 1'b0);
    expect_at(q + 56, "pend_apply55", 16'd56, 4'b1111, 1'b0);
    expect_at(q + 61, "pend_apply60", 16'd61, 4'b1110, 1'b0);

    // Stage period=49, then reset mid-period: staging must be discarded.
    step_to(q + 65);
    period_i = 16'd49;
    load_i   = 1'b1;
    step_to(q + 66);
    load_i = 1'b0;
    step_to(q + 70);
    #1;
    reset_i  = 1'b1;
    enable_i = 1'b0;
    expect_at(q + 70, "async_reset", 16'd0, 4'b0100, 1'b0);
    step_to(q + 72);
    reset_i = 1'b0;
    expect_at(q + 75, "post_reset_idle", 16'd0, 4'b0100, 1'b0);
    step_to(q + 75);
    enable_i = 1'b1;
    r = cyc;
    expect_at(r + 60,  "rst_period_60",  16'd60,  4'b0100, 1'b0);
    expect_at(r + 100, "rst_period_100", 16'd100, 4'b0100, 1'b0);

    // Period 0: counter stays at 0 and overflow fires every tick.
    step_to(r + 100);
    enable_i = 1'b0;
    step_to(r + 101);
    period_i = 16'd0;
    for (int i = 0; i < 4; i++) begin
      c1[i] = '0;
      c2[i] = '0;
    end
    load_i = 1'b1;
    step_to(r + 102);
    load_i   = 1'b0;
    enable_i = 1'b1;
    s = cyc;
    expect_at(s + 1, "per0_tick1", 16'd0, 4'b0100, 1'b1);
    expect_at(s + 2, "per0_tick2", 16'd0, 4'b0100, 1'b1);
    expect_at(s + 3, "per0_tick3", 16'd0, 4'b0100, 1'b1);

    for (int i = 0; i < 20 && q_cyc.size() > 0; i++) begin
      @(posedge clk);
    end
    #6;
    if (q_cyc.size() > 0) begin
      n_cmp += q_cyc.size();
      n_bad += q_cyc.size();
      $display("FAIL drain: %0d expectations never compared", q_cyc.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
